serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial addition controller built around the team's half_adder cell.
//  Accepts two W-bit operands plus carry-in over a valid/ready handshake.
//  Sequences them LSB-first through one shared 1-bit full adder, built from
//  two half_adder instances, one bit per clock.
//  Presents the W-bit sum and carry-out over a second valid/ready handshake.
//  Area-minimal adder for wide operands where latency is acceptable.
// PARAMETERS
//  W   8   operand/sum width in bits; legal range 1..32
// PORTS
//  clk        in   1  single clock, all state updates on posedge
//  rst        in   1  reset: synchronous, active-high
//  in_valid   in   1  operand set offered
//  in_ready   out  1  controller can accept operands (IDLE only)
//  a          in   W  operand A
//  b          in   W  operand B
//  cin        in   1  carry-in
//  out_valid  out  1  sum/cout valid and held
//  out_ready  in   1  consumer takes result
//  sum        out  W  A+B+cin, low W bits
//  cout       out  1  carry out of bit W-1
//  busy       out  1  high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE, bit counter=0, sum=0, cout=0.
//   - Therefore in_ready=1, out_valid=0, busy=0 from the next cycle.
//   - rst has priority over every other input.
//   - rst mid-RUN/DONE aborts; the partial result is discarded and never flagged valid.
//  States:
//   - IDLE: in_ready=1. On in_valid&&in_ready:
//     - latch a->sa, b->sb, cin->carry; clear sum register and counter.
//     - go to RUN.
//     - in_valid while in RUN/DONE is ignored; operands are not queued.
//   - RUN: each cycle the full adder computes s=sa[0]^sb[0]^carry and
//     c=majority(sa[0],sb[0],carry).
//     - sa,sb shift right one bit.
//     - sum register shifts right with s entering at bit W-1.
//     - carry<=c; counter++.
//     - On the cycle counter==W-1 go to DONE; cout<=c on that edge.
//   - DONE: out_valid=1; sum/cout held stable, unaffected by a/b/cin.
//     - On out_valid&&out_ready go to IDLE.
//     - Stall indefinitely while out_ready=0.
//  Latency:
//   - Accept edge = E0. RUN occupies edges E1..EW.
//   - out_valid is high in the cycle after EW, i.e. W cycles after acceptance.
//  Throughput: one add per W+2 cycles minimum (accept, W RUN, 1 DONE handshake).
//   - No same-cycle out->in bypass: in_ready rises the cycle after the output handshake.
//  Arithmetic: sum is modulo 2^W; cout = bit W of the true (W+1)-bit result.
//  Boundaries:
//   - W=1: a single RUN cycle. Counter width = max(1,$clog2(W)).
//   - out_ready high in IDLE/RUN: no effect.
//   - in_ready and out_valid are never high together.
//   - busy == ~in_ready at all times.
// STRUCTURE
//  Shared header serial_add_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   - ST_DONE+1 is illegal and decodes to IDLE.
//  Sub-module fa_from_ha: 1-bit full adder built as two half_adder instances
//   plus an OR of their carries.
//  This controller instantiates exactly one fa_from_ha.
//  Remaining logic: FSM, counter, three W-bit shift registers, carry flop.
// TESTING
//  1. W=4: rst 2 cycles -> in_ready=1, out_valid=0, sum=0, cout=0.
//  2. W=4: a=4'h3, b=4'h5, cin=0 -> after 4 cycles out_valid=1, sum=4'h8, cout=0.
//  3. W=4: a=4'hF, b=4'h1, cin=1 -> sum=4'h1, cout=1.
//     - Hold out_ready=0 10 cycles: result stable and in_ready=0 throughout.
//  4. Toggle a/b/in_valid during RUN -> ignored; result matches the latched operands.
//  5. Assert rst at the 2nd RUN cycle -> IDLE next cycle, out_valid never pulses.
//     - A new a=4'h7, b=4'h7 then gives sum=4'hE, cout=0.
//  6. W=1 and W=8, back-to-back with out_ready=1: 200 random ops.
//     - Each result equals the reference {cout,sum}.
//     - Inter-accept spacing is W+2 cycles.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and
// the bit-counter width helper.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_from_ha.sv
// One-bit full adder composed of two half adders and an OR of their carries.
module fa_from_ha (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell: sum and carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: operands accepted over a valid/ready handshake,
// summed LSB-first through one shared full adder, result held until taken.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// RUN     | one bit per cycle through the full adder
// DONE    | result valid and held until out_ready
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CW = cnt_width(W);

  state_e         state_q;
  state_e         state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   sa_q;
  logic [W-1:0]   sb_q;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic           cout_q;
  logic           fa_s;
  logic           fa_c;
  logic           last_bit;

  fa_from_ha u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The unused encoding reports neither ready nor valid, so busy stays ~in_ready.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = ~in_ready;
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sa_q    <= a;
            sb_q    <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          // New sum bit enters at the MSB so the LSB lands at bit 0 after W shifts.
          sum_q   <= (sum_q >> 1) | (W'(fa_s) << (W - 1));
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) cout_q <= fa_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at W=4, W=1 and W=8 against an
// arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int NI = 3;
  localparam int WID [NI] = '{4, 1, 8};

  logic        clk;
  logic        rst;
  logic        in_valid  [NI];
  logic        out_ready [NI];
  logic        cin_v     [NI];
  logic [31:0] a_v       [NI];
  logic [31:0] b_v       [NI];
  logic        in_ready_o  [NI];
  logic        out_valid_o [NI];
  logic        cout_o      [NI];
  logic        busy_o      [NI];
  logic [31:0] sum_o       [NI];
  logic [3:0]  sum4;
  logic [0:0]  sum1;
  logic [7:0]  sum8;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_viol;
  int unsigned cyc;
  logic        inv_en;

  serial_add_ctrl #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .cin(cin_v[0]), .out_valid(out_valid_o[0]),
    .out_ready(out_ready[0]), .sum(sum4), .cout(cout_o[0]), .busy(busy_o[0])
  );

  serial_add_ctrl #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .cin(cin_v[1]), .out_valid(out_valid_o[1]),
    .out_ready(out_ready[1]), .sum(sum1), .cout(cout_o[1]), .busy(busy_o[1])
  );

  serial_add_ctrl #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_o[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .out_valid(out_valid_o[2]),
    .out_ready(out_ready[2]), .sum(sum8), .cout(cout_o[2]), .busy(busy_o[2])
  );

  assign sum_o[0] = {28'd0, sum4};
  assign sum_o[1] = {31'd0, sum1};
  assign sum_o[2] = {24'd0, sum8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake invariants watched continuously on every instance.
  always @(negedge clk) begin
    if (inv_en) begin
      for (int k = 0; k < NI; k++) begin
        if (busy_o[k] !== ~in_ready_o[k]) n_viol <= n_viol + 1;
        if (in_ready_o[k] && out_valid_o[k]) n_viol <= n_viol + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_add(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic ci);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((64'(av) & m) + (64'(bv) & m) + 64'(ci)) & ((m << 1) | 64'd1);
  endfunction

  function automatic logic [63:0] observed(input int sel);
    return (64'(cout_o[sel]) << WID[sel]) | 64'(sum_o[sel]);
  endfunction

  task automatic start_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci);
    chk("ready_before_accept", 64'(in_ready_o[sel]), 64'd1);
    a_v[sel] = av;
    b_v[sel] = bv;
    cin_v[sel] = ci;
    in_valid[sel] = 1'b1;
    step();
    in_valid[sel] = 1'b0;
  endtask

  // Waits for out_valid; optionally scrambles inputs during RUN.
  task automatic wait_valid(input int sel, input bit scramble, output int n);
    n = 0;
    while (!out_valid_o[sel] && n < 100) begin
      if (scramble) begin
        a_v[sel] = $urandom;
        b_v[sel] = $urandom;
        cin_v[sel] = 1'($urandom);
        in_valid[sel] = 1'($urandom);
        out_ready[sel] = 1'($urandom);
      end
      step();
      n++;
    end
    in_valid[sel] = 1'b0;
  endtask

  task automatic take_result(input int sel);
    out_ready[sel] = 1'b1;
    step();
    out_ready[sel] = 1'b0;
    chk("ready_after_take", 64'(in_ready_o[sel]), 64'd1);
  endtask

  int          lat;
  logic [63:0] expv;
  logic        seen_valid;
  int          prev_acc;
  int          acc;
  int          guard;

  initial begin
    n_cmp = 0; n_bad = 0; n_viol = 0; cyc = 0; inv_en = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; cin_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0;
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    inv_en = 1'b1;
    chk("rst_in_ready", 64'(in_ready_o[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o[0]), 64'd0);
    chk("rst_sum", 64'(sum_o[0]), 64'd0);
    chk("rst_cout", 64'(cout_o[0]), 64'd0);
    chk("rst_busy", 64'(busy_o[0]), 64'd0);

    start_op(0, 32'h3, 32'h5, 1'b0);
    chk("busy_in_run", 64'(busy_o[0]), 64'd1);
    wait_valid(0, 1'b0, lat);
    chk("lat_3p5", 64'(lat), 64'd4);
    chk("res_3p5", observed(0), 64'h08);
    take_result(0);

    start_op(0, 32'hF, 32'h1, 1'b1);
    wait_valid(0, 1'b0, lat);
    chk("lat_fp1", 64'(lat), 64'd4);
    chk("res_fp1", observed(0), 64'h11);
    for (int i = 0; i < 10; i++) begin
      a_v[0] = $urandom; b_v[0] = $urandom; cin_v[0] = 1'($urandom);
      in_valid[0] = 1'($urandom);
      step();
      chk("stall_valid", 64'(out_valid_o[0]), 64'd1);
      chk("stall_in_ready", 64'(in_ready_o[0]), 64'd0);
      chk("stall_result", observed(0), 64'h11);
    end
    in_valid[0] = 1'b0;
    take_result(0);

    start_op(0, 32'h9, 32'h6, 1'b1);
    wait_valid(0, 1'b1, lat);
    chk("lat_scramble", 64'(lat), 64'd4);
    chk("res_scramble", observed(0), ref_add(4, 32'h9, 32'h6, 1'b1));
    take_result(0);

    start_op(0, 32'h5, 32'h6, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready_o[0]), 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_o[0]) seen_valid = 1'b1;
      step();
    end
    chk("abort_no_valid", 64'(seen_valid), 64'd0);
    start_op(0, 32'h7, 32'h7, 1'b0);
    wait_valid(0, 1'b0, lat);
    chk("res_7p7", observed(0), 64'h0E);
    take_result(0);

    for (int sel = 1; sel < NI; sel++) begin
      out_ready[sel] = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 200; i++) begin
        a_v[sel] = $urandom;
        b_v[sel] = $urandom;
        cin_v[sel] = 1'($urandom);
        in_valid[sel] = 1'b1;
        guard = 0;
        while (!in_ready_o[sel] && guard < 50) begin
          step();
          guard++;
        end
        chk("accept_timeout", 64'(guard < 50), 64'd1);
        acc = int'(cyc);
        expv = ref_add(WID[sel], a_v[sel], b_v[sel], cin_v[sel]);
        step();
        // Keep in_valid high and operands moving while busy; must be ignored.
        a_v[sel] = $urandom;
        b_v[sel] = $urandom;
        if (i > 0) chk("spacing", 64'(acc - prev_acc), 64'(WID[sel] + 2));
        prev_acc = acc;
        lat = 0;
        while (!out_valid_o[sel] && lat < 100) begin
          step();
          lat++;
        end
        chk("rand_lat", 64'(lat), 64'(WID[sel]));
        chk("rand_result", observed(sel), expv);
      end
      in_valid[sel] = 1'b0;
      step();
      out_ready[sel] = 1'b0;
    end

    step();
    chk("invariants", 64'(n_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
